// File: rtl/riscv_core.sv
// Single-cycle RV32I-subset core (ADDI/ADD/SUB/OR/AND; XORI/ORI/ANDI/SLTI/XOR/SLT with RISCV_IALU_EXT_EN).
// One instruction retires per clk, result in regfile after one edge; no backpressure, never stalls.
module riscv_core #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] pc;
    logic [31:0] instr_mem [0:IMEM_DEPTH-1];
    logic [31:0] regfile   [0:31];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] result;
    logic        legal;
    logic        unused_pc_bits;

    // pc[1:0] and bits above the memory index do not take part in fetch
    assign unused_pc_bits = ^{pc[31:AW+2], pc[1:0]};

    assign instr  = instr_mem[pc[AW+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm    = {{20{instr[31]}}, instr[31:20]};
    assign op1    = (rs1 == 5'd0) ? 32'h0 : regfile[rs1];
    assign op2    = (rs2 == 5'd0) ? 32'h0 : regfile[rs2];

    always_comb begin
        legal  = 1'b0;
        result = 32'h0;
        case (opcode)
            7'b0010011: begin
                case (funct3)
                    3'b000: begin legal = 1'b1; result = op1 + imm; end
`ifdef RISCV_IALU_EXT_EN
                    3'b100: begin legal = 1'b1; result = op1 ^ imm; end
                    3'b110: begin legal = 1'b1; result = op1 | imm; end
                    3'b111: begin legal = 1'b1; result = op1 & imm; end
                    3'b010: begin
                        legal  = 1'b1;
                        result = ($signed(op1) < $signed(imm)) ? 32'h1 : 32'h0;
                    end
`endif
                    default: ;
                endcase
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: begin legal = 1'b1; result = op1 + op2; end
                        3'b110: begin legal = 1'b1; result = op1 | op2; end
                        3'b111: begin legal = 1'b1; result = op1 & op2; end
`ifdef RISCV_IALU_EXT_EN
                        3'b100: begin legal = 1'b1; result = op1 ^ op2; end
                        3'b010: begin
                            legal  = 1'b1;
                            result = ($signed(op1) < $signed(op2)) ? 32'h1 : 32'h0;
                        end
`endif
                        default: ;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal  = 1'b1;
                    result = op1 - op2;
                end
            end
            default: ;
        endcase
    end

    // instr_mem is deliberately untouched here so a preloaded program survives reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= 32'h0;
            end
        end else begin
            pc <= pc + 32'd4;
            if (legal && rd != 5'd0) begin
                regfile[rd] <= result;
            end
        end
    end

endmodule

// File: tb/tb_riscv_core.sv
// Scoreboard bench for riscv_core: expected register values are queued as programs are loaded.
module tb_riscv_core;
    localparam int IMEM_DEPTH = 64;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [31:0] base_prog [0:5];

    riscv_core #(.IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_mem();
        for (int i = 0; i < IMEM_DEPTH; i++) dut.instr_mem[i] = 32'h0;
    endtask

    task automatic load_base();
        clear_mem();
        for (int i = 0; i < 6; i++) dut.instr_mem[i] = base_prog[i];
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        run(1);
        rst = 1'b1;
    endtask

    task automatic push_base();
        sb.push_back('{1, 32'd5});
        sb.push_back('{2, 32'd10});
        sb.push_back('{3, 32'd15});
        sb.push_back('{4, 32'd5});
        sb.push_back('{5, 32'd15});
        sb.push_back('{6, 32'd0});
        sb.push_back('{7, 32'd0});
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        run(1);
        checks++;
        if (dut.pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'h0);
        end
        for (int i = 0; i < 32; i++) sb.push_back('{i, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.regfile[e.idx] !== e.val) begin
                errors++;
                $display("FAIL reset_x%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_base_program();
        exp_t e;
        load_base();
        apply_reset();
        push_base();
        run(8);
        checks++;
        if (dut.pc !== 32'd32) begin
            errors++;
            $display("FAIL base_pc: got %h expected %h", dut.pc, 32'd32);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.regfile[e.idx] !== e.val) begin
                errors++;
                $display("FAIL base_x%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
            end
        end
    endtask

    task automatic test_sub_wrap();
        exp_t e;
        clear_mem();
        dut.instr_mem[0] = 32'h00500093;
        dut.instr_mem[1] = 32'h00A00113;
        dut.instr_mem[2] = 32'h402081B3;
        dut.instr_mem[3] = 32'hFFF00393;
        apply_reset();
        sb.push_back('{3, 32'hFFFFFFFB});
        sb.push_back('{7, 32'hFFFFFFFF});
        run(4);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.regfile[e.idx] !== e.val) begin
                errors++;
                $display("FAIL sub_wrap_x%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
            end
        end
    endtask

    task automatic test_x0();
        clear_mem();
        dut.instr_mem[0] = 32'h00500013;
        apply_reset();
        run(1);
        checks++;
        if (dut.regfile[0] !== 32'h0) begin
            errors++;
            $display("FAIL x0_write: got %h expected %h", dut.regfile[0], 32'h0);
        end
        checks++;
        if (dut.pc !== 32'd4) begin
            errors++;
            $display("FAIL x0_pc: got %h expected %h", dut.pc, 32'd4);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        load_base();
        apply_reset();
        run(3);
        checks++;
        if (dut.pc !== 32'd12 || dut.regfile[3] !== 32'd15) begin
            errors++;
            $display("FAIL mid_pre: got pc %h x3 %h expected pc %h x3 %h",
                     dut.pc, dut.regfile[3], 32'd12, 32'd15);
        end
        rst = 1'b0;
        run(1);
        checks++;
        if (dut.pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_pc: got %h expected %h", dut.pc, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.regfile[i] !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset_x%0d: got %h expected %h", i, dut.regfile[i], 32'h0);
            end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut.instr_mem[i] !== base_prog[i]) begin
                errors++;
                $display("FAIL mid_reset_imem%0d: got %h expected %h", i, dut.instr_mem[i], base_prog[i]);
            end
        end
        rst = 1'b1;
        push_base();
        run(8);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.regfile[e.idx] !== e.val) begin
                errors++;
                $display("FAIL rerun_x%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
            end
        end
    endtask

    task automatic test_nop_wrap();
        exp_t e;
        clear_mem();
        apply_reset();
        run(IMEM_DEPTH - 1);
        checks++;
        if (dut.pc !== 32'(4 * (IMEM_DEPTH - 1))) begin
            errors++;
            $display("FAIL nop_pc_last: got %h expected %h", dut.pc, 32'(4 * (IMEM_DEPTH - 1)));
        end
        for (int i = 0; i < 32; i++) sb.push_back('{i, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.regfile[e.idx] !== e.val) begin
                errors++;
                $display("FAIL nop_x%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
            end
        end
        run(1);
        checks++;
        if (dut.pc !== 32'(4 * IMEM_DEPTH)) begin
            errors++;
            $display("FAIL wrap_pc: got %h expected %h", dut.pc, 32'(4 * IMEM_DEPTH));
        end
        // word 0 is fetched again once the index wraps
        dut.instr_mem[0] = 32'h00700493;
        sb.push_back('{9, 32'd7});
        run(1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.regfile[e.idx] !== e.val) begin
                errors++;
                $display("FAIL wrap_fetch_x%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
            end
        end
    endtask

    task automatic test_ext();
        exp_t e;
        clear_mem();
        dut.instr_mem[0] = 32'h00500093;
        dut.instr_mem[1] = 32'h0030C413;
        apply_reset();
        sb.push_back('{1, 32'd5});
`ifdef RISCV_IALU_EXT_EN
        sb.push_back('{8, 32'd6});
`else
        sb.push_back('{8, 32'd0});
`endif
        run(3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.regfile[e.idx] !== e.val) begin
                errors++;
                $display("FAIL ext_x%0d: got %h expected %h", e.idx, dut.regfile[e.idx], e.val);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        base_prog[0] = 32'h00500093;
        base_prog[1] = 32'h00A00113;
        base_prog[2] = 32'h002081B3;
        base_prog[3] = 32'h40110233;
        base_prog[4] = 32'h0020E2B3;
        base_prog[5] = 32'h0020F3B3;
        clear_mem();
        test_reset();
        test_base_program();
        test_sub_wrap();
        test_x0();
        test_mid_reset();
        test_nop_wrap();
        test_ext();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
